mult_seq_hs: RTL

Iterative shift-add multiplier with a start/done handshake, parametrised in operand width; the successor to the fixed 8-bit multi-cycle multiplier in the `mult` family. Operands are captured on `start`, and one partial product is accumulated per clock. The full-width product is presented with a one-cycle `done` pulse and held until the next accepted `start`. Optional two's-complement mode is compiled in with a macro.

---
 rtl/mult_seq_hs.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_seq_hs.sv
// Iterative shift-add multiplier with start/done handshake: one partial product per clock.
// Define MULT_SIGNED_EN to compile in two's-complement operation selected by sgn.
module mult_seq_hs #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     dA,
    input  logic [WIDTH-1:0]     dB,
    output logic [2*WIDTH-1:0]   a_mult_b,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;

    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic                 neg_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_d;

`ifdef MULT_SIGNED_EN
    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    always_comb begin
        mag_a_d = (sgn && dA[WIDTH-1]) ? (-dA) : dA;
        mag_b_d = (sgn && dB[WIDTH-1]) ? (-dB) : dB;
        neg_d   = sgn & (dA[WIDTH-1] ^ dB[WIDTH-1]);
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    always_comb begin
        mag_a_d = dA;
        mag_b_d = dB;
        neg_d   = 1'b0;
    end
`endif

    // mcand_q is pre-shifted each cycle, so it always carries the current iteration's weight.
    always_comb begin
        acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_d = neg_q ? (-acc_d) : acc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            a_mult_b <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
                        mplier_q <= mag_b_d;
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH);
                        neg_q    <= neg_d;
                        busy     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q  <= DONE;
                        a_mult_b <= prod_d;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
